rr_grant_sched: RTL
===================

# rr_grant_sched

Round-robin scheduler that shares one 8-way one-hot select datapath among eight requesters. It arbitrates a request vector and holds a single grant until the owner releases or a hold limit expires. It drives both a 3-bit binary index for the 3-to-8 select decoder and the matching one-hot grant. The block sits between requesting agents and the shared decoder-selected resource.

## Interface
- MAX_HOLD, 16, maximum cycles one grant may be held before forced rotation; legal range 2..255
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i = requester i wants the resource, held high while in use
- gnt  output  8  one-hot grant; all-zero when no grant active
- gnt_idx  output  3  binary index of granted requester, feeds decoder select (bit 2 = MSB)
- gnt_vld  output  1  high while a grant is active; equals |gnt
- timeout  output  1  one-cycle pulse when a grant is revoked by hold limit

## Operation
- Reset: state IDLE, gnt=8'h00, gnt_idx=3'd0, gnt_vld=0, timeout=0, priority pointer ptr=3'd0, hold counter=0.
- States: IDLE -> GRANT -> GAP -> IDLE.
- IDLE: if req != 0, select the first set bit scanning ptr, ptr+1, ... ptr+7 (mod 8); register gnt (one-hot), gnt_idx, gnt_vld=1; load hold counter 0; go GRANT. If req == 0, stay IDLE.
- GRANT: each cycle sample req[gnt_idx].
  - req[gnt_idx]=0: clear gnt/gnt_vld, ptr <= gnt_idx+1 (3-bit wrap, 7->0), go GAP.
  - req[gnt_idx]=1 and hold counter == MAX_HOLD-1 (timeout enabled): clear gnt/gnt_vld, timeout=1 for that cycle, ptr <= gnt_idx+1, go GAP.
  - else hold counter increments; grant unchanged.
- GAP: one idle cycle, gnt=0, always -> IDLE. Guarantees no back-to-back grants to different owners without a dead cycle.
- Changes to other req bits during GRANT are ignored; they are considered at next IDLE.
- gnt_idx holds its last value outside GRANT (only reset clears it); consumers qualify with gnt_vld.
- gnt is always zero or exactly one-hot and always equals 1<<gnt_idx when gnt_vld=1.
- Hold counter is 8 bits; never wraps since it is cleared on each grant.

## Timing
- Request-to-grant: req seen high at edge k in IDLE -> gnt high after edge k (visible cycle k+1).
- Release-to-clear: req[gnt_idx] seen low at edge k -> gnt low after edge k.
- Minimum grant length 1 cycle; minimum spacing between grants 1 GAP cycle plus 1 IDLE arbitration cycle (grant-to-grant turnaround 2 cycles).
- Timeout: grant high for exactly MAX_HOLD cycles, then timeout pulse coincides with first cycle of gnt=0.
- Reset asserted mid-GRANT: at that edge all outputs return to reset values, ptr=0; no timeout pulse.
- Simultaneous release and timeout on the same edge: treat as release, timeout stays 0.
- All outputs registered; no combinational path from req to any output.

## Configuration
- RR_TIMEOUT_EN defined: hold counter and forced rotation active as above; timeout pulses.
- RR_TIMEOUT_EN undefined: hold counter and timeout logic removed; grant held until owner drops req; timeout tied 0; MAX_HOLD unused.

## Test plan
- Reset then req=8'h00 for 10 cycles -> gnt=0, gnt_vld=0, gnt_idx=0, timeout=0 throughout.
- req=8'h01 one cycle after reset -> next cycle gnt=8'h01, gnt_idx=0; drop req -> gnt=0 next cycle, ptr=1.
- req=8'hFF held, each owner drops its bit after 3 granted cycles then re-raises -> grant order 0,1,2,...,7,0 with 2-cycle gaps.
- RR_TIMEOUT_EN, MAX_HOLD=16, req=8'h24 held constant -> gnt=8'h04 for 16 cycles, timeout pulse, then gnt=8'h20 for 16 cycles, timeout, then gnt=8'h04.
- req=8'h80 granted, assert sys_rst on 5th granted cycle -> outputs to reset values on that edge; after release of reset with req=8'h81 -> gnt=8'h01 (ptr restarted at 0).
- Without RR_TIMEOUT_EN, req=8'h03 held 100 cycles -> gnt=8'h01 entire time, timeout never high.

Source files
------------

// File: rtl/rr_grant_sched.sv
// rr_grant_sched: round-robin grant scheduler for an 8-way one-hot select.
// Optional hold limit with forced rotation enabled by RR_TIMEOUT_EN.
module rr_grant_sched #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] idx_q, idx_d;
    logic       vld_q, vld_d;
    logic       to_q, to_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] pick;
    logic       any_req;
    logic       own_req;
    logic       hold_last;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("rr_grant_sched: MAX_HOLD must be 2..255");
    end

    assign any_req = |req;
    assign own_req = req[idx_q];

    // Rotating priority search: lowest offset from ptr wins.
    always_comb begin
        pick = ptr_q;
        for (int i = 7; i >= 0; i--) begin
            if (req[ptr_q + 3'(i)]) begin
                pick = ptr_q + 3'(i);
            end
        end
    end

`ifdef RR_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] hold_q, hold_d;

    assign hold_last = (hold_q == HOLD_LAST);

    // Hold counter: cleared on each new grant, counts held cycles.
    always_comb begin
        hold_d = hold_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    hold_d = 8'd0;
                end
            end
            S_GRANT: begin
                if (own_req && !hold_last) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: begin
                hold_d = hold_q;
            end
        endcase
    end

    // Hold counter register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hold_q <= 8'd0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign hold_last = 1'b0;
`endif

    // State register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!own_req || hold_last) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output next values; release wins over a coincident hold expiry.
    always_comb begin
        gnt_d = gnt_q;
        idx_d = idx_q;
        vld_d = vld_q;
        to_d  = 1'b0;
        ptr_d = ptr_q;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    gnt_d = 8'b1 << pick;
                    idx_d = pick;
                    vld_d = 1'b1;
                end
            end
            S_GRANT: begin
                if (!own_req || hold_last) begin
                    gnt_d = 8'h00;
                    vld_d = 1'b0;
                    ptr_d = idx_q + 3'd1;
                    to_d  = own_req & hold_last;
                end
            end
            S_GAP: begin
                gnt_d = 8'h00;
                vld_d = 1'b0;
            end
            default: begin
                gnt_d = 8'h00;
                vld_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and priority pointer.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gnt_q <= 8'h00;
            idx_q <= 3'd0;
            vld_q <= 1'b0;
            to_q  <= 1'b0;
            ptr_q <= 3'd0;
        end else begin
            gnt_q <= gnt_d;
            idx_q <= idx_d;
            vld_q <= vld_d;
            to_q  <= to_d;
            ptr_q <= ptr_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = vld_q;
    assign timeout = to_q;

endmodule
